// File: rtl/dds_phase_accumulator.sv
// dds_phase_accumulator: DDS phase accumulator feeding the sine ROM address, phase-continuous FTW update at wrap.
// Optional LFSR phase dither is compiled in with DDS_DITHER_EN.
module dds_phase_accumulator #(
  parameter int unsigned ACC_W = 32,
  parameter int unsigned ADDR_W = 11,
  parameter logic [ACC_W-1:0] FTW_RST = 32'h0020_0000
) (
  input  logic              Fg_CLK,
  input  logic              RESETn,
  input  logic              enable,
  input  logic              sync_clr,
  input  logic [ACC_W-1:0]  ftw_in,
  input  logic              ftw_valid,
  output logic              ftw_ready,
  input  logic [ADDR_W-1:0] phase_ofs,
  output logic [ADDR_W-1:0] Address,
  output logic              addr_valid,
  output logic              wrap
);
  typedef enum logic {IDLE, PENDING} state_t;
  state_t state, state_nxt;
  logic [ACC_W-1:0] acc, ftw_act, ftw_pend, acc_d;
  logic [ACC_W:0] acc_sum;
  logic adv, carry, accept, apply;
  assign acc_sum = {1'b0, acc} + {1'b0, ftw_act};
  assign carry = acc_sum[ACC_W];
  assign adv = !sync_clr && enable;
  assign accept = ftw_valid && ftw_ready;
  // a pending word is applied at the next wrap, or immediately by a sync clear
  assign apply = (state == PENDING) && (sync_clr || (adv && carry));
`ifdef DDS_DITHER_EN
  logic [22:0] lfsr;
  always_ff @(posedge Fg_CLK or negedge RESETn)
    if (!RESETn) lfsr <= 23'h000001;
    else if (adv) lfsr <= {lfsr[21:0], lfsr[22] ^ lfsr[17]};
  assign acc_d = acc + ACC_W'(lfsr[ACC_W-ADDR_W-1:0]);
`else
  assign acc_d = acc;
`endif
  always_ff @(posedge Fg_CLK or negedge RESETn)
    if (!RESETn) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = (state == IDLE) ? (accept ? PENDING : IDLE) : (apply ? IDLE : PENDING);
  always_comb
    ftw_ready = (state == IDLE);
  always_ff @(posedge Fg_CLK or negedge RESETn)
    if (!RESETn) begin
      acc <= '0;
      ftw_act <= FTW_RST;
      ftw_pend <= '0;
      Address <= '0;
      addr_valid <= 1'b0;
      wrap <= 1'b0;
    end else begin
      acc <= sync_clr ? '0 : adv ? acc_sum[ACC_W-1:0] : acc;
      ftw_act <= apply ? ftw_pend : ftw_act;
      ftw_pend <= accept ? ftw_in : ftw_pend;
      Address <= adv ? acc_d[ACC_W-1 -: ADDR_W] + phase_ofs : Address;
      addr_valid <= adv;
      wrap <= adv && carry;
    end
endmodule

// File: tb/tb_dds_phase_accumulator.sv
// tb_dds_phase_accumulator: randomized scoreboard bench against an arithmetic phase model.
module tb_dds_phase_accumulator;
  logic Fg_CLK = 0, RESETn = 0, enable = 0, sync_clr = 0, ftw_valid = 0;
  logic [31:0] ftw_in = 0;
  logic [10:0] phase_ofs = 0;
  logic ftw_ready, addr_valid, wrap;
  logic [10:0] Address;
  typedef struct {int addr; bit wrap;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  longint m_acc, m_act, m_pend;
  bit m_pending, exp_valid;
  int exp_addr;
  logic [22:0] m_lfsr;

  dds_phase_accumulator dut (
    .Fg_CLK(Fg_CLK), .RESETn(RESETn), .enable(enable), .sync_clr(sync_clr),
    .ftw_in(ftw_in), .ftw_valid(ftw_valid), .ftw_ready(ftw_ready),
    .phase_ofs(phase_ofs), .Address(Address), .addr_valid(addr_valid), .wrap(wrap)
  );

  always #5 Fg_CLK = ~Fg_CLK;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_act = 64'h0020_0000; m_pend = 0; m_pending = 0;
    exp_valid = 0; exp_addr = 0; m_lfsr = 23'h000001;
    q.delete();
  endtask

  // phase arithmetic done modulo 2^32 on wide integers; address is the top 11 bits plus offset
  task automatic model_step();
    longint sum, src;
    bit adv, accept;
    adv = !sync_clr && enable;
    accept = ftw_valid && !m_pending;
    sum = m_acc + m_act;
    exp_valid = adv;
    if (sync_clr) begin
      if (m_pending) begin m_act = m_pend; m_pending = 0; end
      m_acc = 0;
    end else if (adv) begin
      src = m_acc;
`ifdef DDS_DITHER_EN
      src = (m_acc + longint'(m_lfsr % (1 << 21))) % 64'h1_0000_0000;
      m_lfsr = {m_lfsr[21:0], m_lfsr[22] ^ m_lfsr[17]};
`endif
      exp_addr = int'((src / 64'h20_0000 + longint'(phase_ofs)) % 2048);
      q.push_back('{exp_addr, sum >= 64'h1_0000_0000});
      if (sum >= 64'h1_0000_0000 && m_pending) begin m_act = m_pend; m_pending = 0; end
      m_acc = sum % 64'h1_0000_0000;
    end
    if (accept) begin m_pend = longint'(ftw_in); m_pending = 1; end
  endtask

  task automatic tick(bit en, bit clr, bit fv, logic [31:0] fin);
    enable = en; sync_clr = clr; ftw_valid = fv; ftw_in = fin;
    @(posedge Fg_CLK);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    RESETn = 0;
    #1;
    chk("rst_addr", {21'b0, Address}, 0);
    chk("rst_valid", {31'b0, addr_valid}, 0);
    chk("rst_wrap", {31'b0, wrap}, 0);
    chk("rst_ready", {31'b0, ftw_ready}, 1);
    model_reset();
    repeat (2) @(posedge Fg_CLK);
    #1 RESETn = 1;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge Fg_CLK);
      if (RESETn) begin
        chk("ftw_ready", {31'b0, ftw_ready}, {31'b0, !m_pending});
        chk("addr_valid", {31'b0, addr_valid}, {31'b0, exp_valid});
        if (addr_valid) begin
          if (q.size() == 0) begin
            errors++; checks++;
            $display("FAIL unexpected_valid: got Address %0h expected no output", Address);
          end else begin
            e = q.pop_front();
            chk("address", {21'b0, Address}, e.addr);
            chk("wrap", {31'b0, wrap}, {31'b0, e.wrap});
          end
        end else begin
          chk("wrap_idle", {31'b0, wrap}, 0);
          chk("addr_hold", {21'b0, Address}, exp_addr);
        end
      end
    end
  end

  initial begin
    logic [31:0] fin;
    model_reset();
    #2 do_reset();
    repeat (2050) tick(1, 0, 0, 0);
    do_reset();
    phase_ofs = 11'h400;
    repeat (2050) tick(1, 0, 0, 0);
    do_reset();
    phase_ofs = 0;
    repeat (700) tick(1, 0, 0, 0);
    tick(1, 0, 1, 32'h0040_0000);
    repeat (5) tick(1, 0, 1, $urandom);
    repeat (1500) tick(1, 0, 0, 0);
    tick(1, 0, 1, 32'h0060_0000);
    repeat (50) tick(1, 0, 0, 0);
    tick(1, 1, 0, 0);
    repeat (10) tick(1, 0, 0, 0);
    tick(1, 0, 0, 0); tick(0, 0, 0, 0); tick(0, 0, 0, 0); tick(1, 0, 0, 0);
    tick(1, 0, 1, 32'h0010_0000);
    repeat (3) tick(1, 0, 0, 0);
    do_reset();
    repeat (10) tick(1, 0, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      case ($urandom_range(0, 3))
        0: fin = 0;
        1: fin = 32'h8000_0000 | $urandom;
        default: fin = $urandom_range(0, 32'h00FF_FFFF);
      endcase
      if ($urandom_range(0, 99) < 3) phase_ofs = 11'($urandom);
      if ($urandom_range(0, 999) < 2) do_reset();
      tick($urandom_range(0, 99) < 80, $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 5, fin);
    end
    tick(0, 0, 0, 0);
    @(negedge Fg_CLK);
    #1 chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
